proc_mem_port_arbiter: RTL

Merges the pipelined processor's instruction-memory and data-memory request ports onto a single shared memory port. Responses are routed back to the issuing port. It sits directly downstream of the processor's imem bypass queue and dmem request pack, and upstream of the cache or test memory.
The block does round-robin arbitration and tags each request by port in opaque[0]. A per-port outstanding-request limit keeps the response path from backing up into the wrong port.
All message ports carry the label of the `domain` input; the block itself makes no security decisions.

---
 rtl/proc_mem_port_arbiter_pkg.sv | 49 ++++
 rtl/proc_mem_req_out_reg.sv | 29 ++
 rtl/proc_mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/proc_mem_port_arbiter_pkg.sv
// Shared definitions for the processor memory port arbiter.
// Message field positions, port ids and the outstanding-counter width.
// Counter update helper shared by both per-port counters.
package proc_mem_port_arbiter_pkg;

  // Request message {type, opaque, addr, len, data}
  localparam int REQ_W         = 77;
  localparam int REQ_TYPE_LSB  = 74;
  localparam int REQ_OPQ_LSB   = 66;
  localparam int REQ_ADDR_LSB  = 34;
  localparam int REQ_LEN_LSB   = 32;
  localparam int REQ_DATA_LSB  = 0;

  // Response message {type, opaque, len, data}
  localparam int RESP_W        = 45;
  localparam int RESP_TYPE_LSB = 42;
  localparam int RESP_OPQ_LSB  = 34;
  localparam int RESP_LEN_LSB  = 32;
  localparam int RESP_DATA_LSB = 0;

  // Field widths
  localparam int TYPE_W = 3;
  localparam int OPQ_W  = 8;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 2;
  localparam int DATA_W = 32;

  // Port ids carried in opaque[0]
  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  // Outstanding-request counter width (limit up to 15)
  localparam int CNT_W = 4;

  // Next counter value: simultaneous inc/dec cancel, decrement saturates at 0
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                               input logic inc,
                                               input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/proc_mem_req_out_reg.sv
// One-entry request pipe register feeding the shared memory port.
// Latency: load at edge N is visible on the outputs from N+1.
// Backpressure: holds its entry until dequeued; load may coincide with dequeue.
module proc_mem_req_out_reg
  import proc_mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [REQ_W-1:0] load_msg,
  input  logic             deq,
  output logic             full,
  output logic [REQ_W-1:0] msg
);

  // Load has priority over dequeue so a refill in the draining cycle keeps the entry full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      msg  <= '0;
    end else if (load) begin
      full <= 1'b1;
      msg  <= load_msg;
    end else if (deq) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/proc_mem_port_arbiter.sv
// Round-robin merge of imem/dmem request ports onto one memory port; responses routed by opaque[0].
// Latency: request 1 cycle (registered), response 0 cycles (combinational pass-through).
// Backpressure: per-port rdy needs grant, free/draining register and outstanding count below the limit.
module proc_mem_port_arbiter
  import proc_mem_port_arbiter_pkg::*;
#(
  parameter int p_max_outstanding = 4,
  parameter int p_opaque_nbits    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              domain,

  input  logic [REQ_W-1:0]  imemreq_msg,
  input  logic              imemreq_val,
  output logic              imemreq_rdy,
  output logic [RESP_W-1:0] imemresp_msg,
  output logic              imemresp_val,
  input  logic              imemresp_rdy,

  input  logic [REQ_W-1:0]  dmemreq_msg,
  input  logic              dmemreq_val,
  output logic              dmemreq_rdy,
  output logic [RESP_W-1:0] dmemresp_msg,
  output logic              dmemresp_val,
  input  logic              dmemresp_rdy,

  output logic [REQ_W-1:0]  memreq_msg,
  output logic              memreq_val,
  input  logic              memreq_rdy,
  input  logic [RESP_W-1:0] memresp_msg,
  input  logic              memresp_val,
  output logic              memresp_rdy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(p_max_outstanding);

  logic                      out_full;
  logic [REQ_W-1:0]          out_msg;
  logic                      can_load;
  logic                      deq;
  logic                      load;
  logic                      elig_imem;
  logic                      elig_dmem;
  logic                      grant_imem;
  logic                      grant_dmem;
  logic                      prio;       // port id currently favoured on a tie
  logic [CNT_W-1:0]          cnt_imem;
  logic [CNT_W-1:0]          cnt_dmem;
  logic                      win_port;
  logic [REQ_W-1:0]          win_msg;
  logic [p_opaque_nbits-1:0] win_opq;
  logic [REQ_W-1:0]          tagged_msg;
  logic                      resp_sel;
  logic                      resp_fire;
  logic [RESP_W-1:0]         resp_fwd;
  logic                      unused_domain;

  // The domain label travels with the messages outside this block; nothing here depends on it
  assign unused_domain = domain;

  // Request side: the register accepts a new entry when empty or draining this cycle
  assign can_load = !out_full || memreq_rdy;
  assign deq      = out_full && memreq_rdy;

  assign elig_imem  = imemreq_val && (cnt_imem < MAX_CNT);
  assign elig_dmem  = dmemreq_val && (cnt_dmem < MAX_CNT);
  assign grant_dmem = elig_dmem && (!elig_imem || (prio == PORT_DMEM));
  assign grant_imem = elig_imem && (!elig_dmem || (prio == PORT_IMEM));

  assign imemreq_rdy = grant_imem && can_load;
  assign dmemreq_rdy = grant_dmem && can_load;
  assign load        = imemreq_rdy || dmemreq_rdy;

  // Winner's message with opaque[0] replaced by its port id
  assign win_port   = grant_dmem ? PORT_DMEM : PORT_IMEM;
  assign win_msg    = grant_dmem ? dmemreq_msg : imemreq_msg;
  assign win_opq    = win_msg[REQ_OPQ_LSB +: p_opaque_nbits];
  assign tagged_msg = {win_msg[REQ_W-1:REQ_OPQ_LSB+p_opaque_nbits],
                       win_opq[p_opaque_nbits-1:1],
                       win_port,
                       win_msg[REQ_OPQ_LSB-1:0]};

  proc_mem_req_out_reg u_out_reg (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .load_msg (tagged_msg),
    .deq      (deq),
    .full     (out_full),
    .msg      (out_msg)
  );

  assign memreq_val = out_full;
  assign memreq_msg = out_msg;

  // Response side: steer by the tag, and clear it before handing back to the port
  assign resp_sel  = memresp_msg[RESP_OPQ_LSB];
  assign resp_fwd  = {memresp_msg[RESP_W-1:RESP_OPQ_LSB+1], 1'b0,
                      memresp_msg[RESP_OPQ_LSB-1:0]};

  assign imemresp_val = memresp_val && (resp_sel == PORT_IMEM);
  assign dmemresp_val = memresp_val && (resp_sel == PORT_DMEM);
  assign imemresp_msg = resp_fwd;
  assign dmemresp_msg = resp_fwd;
  assign memresp_rdy  = (resp_sel == PORT_DMEM) ? dmemresp_rdy : imemresp_rdy;
  assign resp_fire    = memresp_val && memresp_rdy;

  // Round-robin pointer: after a grant the other port is favoured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= PORT_DMEM;
    end else if (load) begin
      prio <= ~win_port;
    end
  end

  // Outstanding counters: up on request accept, down on response handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_imem <= '0;
      cnt_dmem <= '0;
    end else begin
      cnt_imem <= cnt_next(cnt_imem, imemreq_rdy,
                           resp_fire && (resp_sel == PORT_IMEM));
      cnt_dmem <= cnt_next(cnt_dmem, dmemreq_rdy,
                           resp_fire && (resp_sel == PORT_DMEM));
    end
  end

endmodule
